// File: rtl/scu_dsp_dma.sv
// Bus-side DMA engine for the SCU DSP: holds RA0/WA0 and turns each DSP word request
// into one external bus cycle, returning DMA_ACK/read data and signalling DMA_END.
module scu_dsp_dma #(
   parameter int ADDR_W = 27,
   parameter int RA_INC = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RES_N,
   input  logic              CE_R,
   input  logic              CE_F,
   input  logic [31:0]       DSO,
   input  logic              RA0W,
   input  logic              WA0W,
   input  logic [2:0]        DMA_ADD,
   input  logic [31:0]       DMA_DO,
   input  logic              DMA_WE,
   input  logic              DMA_REQ,
   input  logic              DMA_RUN,
   input  logic              DMA_LAST,
   output logic [31:0]       DMA_DI,
   output logic              DMA_ACK,
   output logic              DMA_END,
   output logic [ADDR_W-1:0] BUS_ADDR,
   output logic [31:0]       BUS_DO,
   input  logic [31:0]       BUS_DI,
   output logic              BUS_WE,
   output logic              BUS_REQ,
   input  logic              BUS_ACK,
   output logic [ADDR_W-1:0] RA0_Q,
   output logic [ADDR_W-1:0] WA0_Q,
   output logic [1:0]        DBG_STATE
);

   typedef enum logic [1:0] {IDLE = 2'd0, BREQ = 2'd1, ACK = 2'd2, ENDW = 2'd3} state_t;

   // Handshake: DMA_REQ is taken only in IDLE; BUS_REQ stays high with address/data/we
   // frozen until the one-cycle BUS_ACK; DMA_ACK then stays high until a CE_R edge.
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ra0_q, ra0_d, wa0_q, wa0_d, bus_addr_q, bus_addr_d;
   logic [31:0]         bus_do_q, bus_do_d, dma_di_q, dma_di_d;
   logic                bus_we_q, bus_we_d, bus_req_q, bus_req_d;
   logic                dma_ack_q, dma_ack_d, dma_end_q, dma_end_d;
   logic                dir_q, dir_d, abort_q, abort_d, end_f_q, end_f_d;
   logic [2:0]          add_sel_q, add_sel_d;
   logic [ADDR_W-1:0]   wr_inc;

   always_comb begin
      wr_inc = '0;
      if (add_sel_q != 3'd0) wr_inc = ADDR_W'(1) << add_sel_q;
   end

   always_comb begin
      state_d    = state_q;
      ra0_d      = ra0_q;
      wa0_d      = wa0_q;
      bus_addr_d = bus_addr_q;
      bus_do_d   = bus_do_q;
      dma_di_d   = dma_di_q;
      bus_we_d   = bus_we_q;
      bus_req_d  = bus_req_q;
      dma_ack_d  = dma_ack_q;
      dma_end_d  = dma_end_q;
      dir_d      = dir_q;
      abort_d    = abort_q;
      end_f_d    = end_f_q;
      add_sel_d  = add_sel_q;
      case (state_q)
         IDLE: begin
            if (DMA_RUN && DMA_REQ && !dma_ack_q) begin
               dir_d      = DMA_WE;
               if (DMA_WE) bus_do_d = DMA_DO;
               bus_addr_d = DMA_WE ? wa0_q : ra0_q;
               add_sel_d  = DMA_ADD;
               bus_req_d  = 1'b1;
               bus_we_d   = DMA_WE;
               abort_d    = 1'b0;
               state_d    = BREQ;
            end
         end
         BREQ: begin
            // A run drop is remembered so the bus cycle can finish cleanly first.
            if (!DMA_RUN) abort_d = 1'b1;
            if (BUS_ACK) begin
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               if (abort_q || !DMA_RUN) begin
                  abort_d = 1'b0;
                  state_d = IDLE;
               end else begin
                  if (!dir_q) dma_di_d = BUS_DI;
                  dma_ack_d = 1'b1;
                  state_d   = ACK;
               end
            end
         end
         ACK: begin
            if (!DMA_RUN) begin
               dma_ack_d = 1'b0;
               state_d   = IDLE;
            end else if (CE_R) begin
               dma_ack_d = 1'b0;
               if (dir_q) wa0_d = wa0_q + wr_inc;
               else       ra0_d = ra0_q + ADDR_W'(RA_INC);
               if (DMA_LAST) begin
                  dma_end_d = 1'b1;
                  end_f_d   = 1'b0;
                  state_d   = ENDW;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         ENDW: begin
            // DMA_END must straddle a CE_F edge so the DSP sees it high then low.
            if (!DMA_RUN) begin
               dma_end_d = 1'b0;
               state_d   = IDLE;
            end else begin
               if (CE_F) end_f_d = 1'b1;
               if (CE_R && end_f_q) begin
                  dma_end_d = 1'b0;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (RA0W) ra0_d = {DSO[ADDR_W-3:0], 2'b00};
      if (WA0W) wa0_d = {DSO[ADDR_W-3:0], 2'b00};
      if (!RES_N) begin
         state_d    = IDLE;
         ra0_d      = '0;
         wa0_d      = '0;
         bus_addr_d = '0;
         bus_do_d   = '0;
         dma_di_d   = '0;
         bus_we_d   = 1'b0;
         bus_req_d  = 1'b0;
         dma_ack_d  = 1'b0;
         dma_end_d  = 1'b0;
         dir_d      = 1'b0;
         abort_d    = 1'b0;
         end_f_d    = 1'b0;
         add_sel_d  = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         ra0_q      <= '0;
         wa0_q      <= '0;
         bus_addr_q <= '0;
         bus_do_q   <= '0;
         dma_di_q   <= '0;
         bus_we_q   <= 1'b0;
         bus_req_q  <= 1'b0;
         dma_ack_q  <= 1'b0;
         dma_end_q  <= 1'b0;
         dir_q      <= 1'b0;
         abort_q    <= 1'b0;
         end_f_q    <= 1'b0;
         add_sel_q  <= '0;
      end else begin
         state_q    <= state_d;
         ra0_q      <= ra0_d;
         wa0_q      <= wa0_d;
         bus_addr_q <= bus_addr_d;
         bus_do_q   <= bus_do_d;
         dma_di_q   <= dma_di_d;
         bus_we_q   <= bus_we_d;
         bus_req_q  <= bus_req_d;
         dma_ack_q  <= dma_ack_d;
         dma_end_q  <= dma_end_d;
         dir_q      <= dir_d;
         abort_q    <= abort_d;
         end_f_q    <= end_f_d;
         add_sel_q  <= add_sel_d;
      end
   end

   assign DMA_DI    = dma_di_q;
   assign DMA_ACK   = dma_ack_q;
   assign DMA_END   = dma_end_q;
   assign BUS_ADDR  = bus_addr_q;
   assign BUS_DO    = bus_do_q;
   assign BUS_WE    = bus_we_q;
   assign BUS_REQ   = bus_req_q;
   assign RA0_Q     = ra0_q;
   assign WA0_Q     = wa0_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_scu_dsp_dma.sv
// Directed bench for scu_dsp_dma: a DSP-side driver, a bus responder, and a monitor that
// checks bus cycles and returned read data against expected queues.
module tb_scu_dsp_dma;
   localparam int AW = 27;

   logic          CLK, RST_N, RES_N, CE_R, CE_F;
   logic [31:0]   DSO, DMA_DO, DMA_DI, BUS_DO, BUS_DI;
   logic          RA0W, WA0W, DMA_WE, DMA_REQ, DMA_RUN, DMA_LAST;
   logic [2:0]    DMA_ADD;
   logic          DMA_ACK, DMA_END, BUS_WE, BUS_REQ, BUS_ACK;
   logic [AW-1:0] BUS_ADDR, RA0_Q, WA0_Q;
   logic [1:0]    DBG_STATE;

   scu_dsp_dma #(.ADDR_W(AW), .RA_INC(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .RES_N(RES_N), .CE_R(CE_R), .CE_F(CE_F),
      .DSO(DSO), .RA0W(RA0W), .WA0W(WA0W), .DMA_ADD(DMA_ADD), .DMA_DO(DMA_DO),
      .DMA_WE(DMA_WE), .DMA_REQ(DMA_REQ), .DMA_RUN(DMA_RUN), .DMA_LAST(DMA_LAST),
      .DMA_DI(DMA_DI), .DMA_ACK(DMA_ACK), .DMA_END(DMA_END), .BUS_ADDR(BUS_ADDR),
      .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .BUS_WE(BUS_WE), .BUS_REQ(BUS_REQ),
      .BUS_ACK(BUS_ACK), .RA0_Q(RA0_Q), .WA0_Q(WA0_Q), .DBG_STATE(DBG_STATE)
   );

   // ---------------- clock / reset / clock enables ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic ce_ph = 1'b0;
   initial begin CE_R = 1'b0; CE_F = 1'b0; end
   always @(negedge CLK) begin
      ce_ph = ~ce_ph;
      CE_R  = ce_ph;
      CE_F  = ~ce_ph;
   end

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [59:0] exp_q[$];      // {we, addr, data} per bus cycle
   logic [31:0] exp_di_q[$];   // read data expected on DMA_DI at DMA_ACK rise
   logic [31:0] rd_q[$];       // data the bus responder returns for reads
   int  ack_delay = 2;
   bit  cur_we = 1'b0;
   bit  abort_mode = 1'b0;
   int  ack_rise_cnt = 0;
   int  end_rise_cnt = 0;
   int  last_req_len = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_bus(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
      exp_q.push_back({we, a, d});
   endtask

   // ---------------- bus responder ----------------
   int wait_cnt = 0;
   initial begin
      BUS_ACK = 1'b0;
      BUS_DI  = '0;
      forever begin
         @(negedge CLK);
         BUS_ACK = 1'b0;
         if (BUS_REQ) begin
            if (wait_cnt >= ack_delay) begin
               BUS_ACK  = 1'b1;
               BUS_DI   = (!BUS_WE && rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   bit prev_req = 0, prev_ack = 0, prev_end = 0, ack_pend = 0, stable = 1, early = 0;
   logic [AW-1:0] held_addr;
   logic [31:0]   held_do;
   logic          held_we;
   int            req_len = 0;
   always begin
      @(negedge CLK);
      #1;
      if (!RST_N) begin
         prev_req = 0; prev_ack = 0; prev_end = 0; ack_pend = 0;
      end else begin
         if (ack_pend) begin
            ack_pend = 0;
            if (!abort_mode) check("ack_latency", 64'(DMA_ACK), 64'd1);
         end
         if (BUS_REQ) begin
            if (!prev_req) begin
               held_addr = BUS_ADDR; held_we = BUS_WE; held_do = BUS_DO;
               stable = 1; early = 0; req_len = 0;
            end else if (BUS_ADDR !== held_addr || BUS_WE !== held_we || BUS_DO !== held_do) begin
               stable = 0;
            end
            if (DMA_ACK) early = 1;
            req_len++;
            if (BUS_ACK) begin
               last_req_len = req_len;
               check("bus_stable", 64'(stable), 64'd1);
               check("ack_before_bus_ack", 64'(early), 64'd0);
               if (exp_q.size() == 0) begin
                  check("bus_unexpected", 64'(BUS_ADDR), 64'd0);
               end else begin
                  logic [59:0] e;
                  e = exp_q.pop_front();
                  check("bus_we", 64'(BUS_WE), 64'(e[59]));
                  check("bus_addr", 64'(BUS_ADDR), 64'(e[58:32]));
                  if (e[59]) check("bus_do", 64'(BUS_DO), 64'(e[31:0]));
               end
               ack_pend = 1;
            end
         end
         if (DMA_ACK && !prev_ack) begin
            ack_rise_cnt++;
            if (!cur_we) begin
               if (exp_di_q.size() == 0) check("dma_di_unexpected", 64'(DMA_DI), 64'd0);
               else check("dma_di", 64'(DMA_DI), 64'(exp_di_q.pop_front()));
            end
         end
         if (DMA_END && !prev_end) end_rise_cnt++;
         prev_req = BUS_REQ; prev_ack = DMA_ACK; prev_end = DMA_END;
      end
   end

   // ---------------- DSP-side driver tasks ----------------
   task automatic load_reg(input bit is_wa, input logic [31:0] v);
      @(negedge CLK);
      DSO = v;
      if (is_wa) WA0W = 1'b1; else RA0W = 1'b1;
      @(negedge CLK);
      WA0W = 1'b0; RA0W = 1'b0;
   endtask

   task automatic issue_req(input logic we, input logic [31:0] d, input logic last);
      @(negedge CLK);
      DMA_REQ = 1'b1; DMA_WE = we; DMA_DO = d; DMA_LAST = last; cur_we = we;
      @(negedge CLK);
      DMA_REQ = 1'b0;
      check("req_latency", 64'(BUS_REQ), 64'd1);
   endtask

   task automatic wait_ack_rise();
      int n = 0;
      while (!DMA_ACK && n < 100) begin @(negedge CLK); n++; end
      if (!DMA_ACK) check("ack_timeout", 64'(DMA_ACK), 64'd1);
   endtask

   task automatic wait_ack_fall();
      int n = 0;
      while (DMA_ACK && n < 10) begin @(negedge CLK); n++; end
      if (DMA_ACK) check("ack_stuck", 64'(DMA_ACK), 64'd0);
      DMA_LAST = 1'b0;
   endtask

   task automatic wait_end_done(input int exp_ends);
      int n = 0;
      while (DMA_END && n < 10) begin @(negedge CLK); n++; end
      check("end_cleared", 64'(DMA_END), 64'd0);
      check("end_count", 64'(end_rise_cnt), 64'(exp_ends));
   endtask

   task automatic xfer(input logic we, input logic [31:0] d, input logic last);
      issue_req(we, d, last);
      wait_ack_rise();
      wait_ack_fall();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      RST_N = 1'b0; RES_N = 1'b1; DSO = '0; RA0W = 0; WA0W = 0; DMA_ADD = '0;
      DMA_DO = '0; DMA_WE = 0; DMA_REQ = 0; DMA_RUN = 0; DMA_LAST = 0;
      repeat (3) @(negedge CLK);
      check("rst_ra0", 64'(RA0_Q), 64'd0);
      check("rst_wa0", 64'(WA0_Q), 64'd0);
      check("rst_outs", 64'({BUS_REQ, BUS_WE, DMA_ACK, DMA_END}), 64'd0);
      check("rst_state", 64'(DBG_STATE), 64'd0);
      RST_N = 1'b1; DMA_RUN = 1'b1;

      // 3-word read from RA0
      load_reg(0, 32'h0010_0400);
      check("ra0_load", 64'(RA0_Q), 64'h40_1000);
      for (int i = 0; i < 3; i++) begin
         push_bus(0, AW'(27'h40_1000 + 4 * i), 32'h0);
         exp_di_q.push_back(32'hA1 + i);
         rd_q.push_back(32'hA1 + i);
      end
      for (int i = 0; i < 3; i++) xfer(0, 32'h0, (i == 2));
      wait_end_done(1);
      check("ra0_after_read", 64'(RA0_Q), 64'h40_100C);

      // 2-word write, step 8
      load_reg(1, 32'h40);
      check("wa0_load", 64'(WA0_Q), 64'h100);
      DMA_ADD = 3'd3;
      push_bus(1, 27'h100, 32'h1234);
      push_bus(1, 27'h108, 32'h5678);
      xfer(1, 32'h1234, 0);
      xfer(1, 32'h5678, 1);
      wait_end_done(2);
      check("wa0_after_write", 64'(WA0_Q), 64'h110);

      // 4-word write with zero step
      DMA_ADD = 3'd0;
      for (int i = 0; i < 4; i++) push_bus(1, 27'h110, 32'hC0DE_0000 + i);
      for (int i = 0; i < 4; i++) xfer(1, 32'hC0DE_0000 + i, (i == 3));
      wait_end_done(3);
      check("wa0_step0", 64'(WA0_Q), 64'h110);

      // bus ack delayed 20 clocks
      ack_delay = 20;
      push_bus(0, 27'h40_100C, 32'h0);
      exp_di_q.push_back(32'hB5);
      rd_q.push_back(32'hB5);
      xfer(0, 32'h0, 1);
      check("slow_req_len", 64'(last_req_len), 64'd21);
      wait_end_done(4);
      check("ra0_after_slow", 64'(RA0_Q), 64'h40_1010);
      ack_delay = 2;

      // DMA_RUN dropped during BREQ
      abort_mode = 1;
      push_bus(0, 27'h40_1010, 32'h0);
      rd_q.push_back(32'hCC);
      begin
         int acks_before;
         acks_before = ack_rise_cnt;
         issue_req(0, 32'h0, 0);
         DMA_RUN = 1'b0;
         repeat (8) @(negedge CLK);
         check("abort_req_len", 64'(last_req_len), 64'd3);
         check("abort_no_ack", 64'(ack_rise_cnt), 64'(acks_before));
         check("abort_no_end", 64'(end_rise_cnt), 64'd4);
         check("abort_ra0", 64'(RA0_Q), 64'h40_1010);
         check("abort_bus_done", 64'(exp_q.size()), 64'd0);
         check("abort_idle", 64'({BUS_REQ, DBG_STATE}), 64'd0);
      end
      DMA_RUN = 1'b1;

      // asynchronous reset in the middle of ACK
      push_bus(0, 27'h40_1010, 32'h0);
      rd_q.push_back(32'hEE);
      issue_req(0, 32'h0, 1);
      wait_ack_rise();
      RST_N = 1'b0;
      #1;
      check("arst_ack", 64'(DMA_ACK), 64'd0);
      check("arst_ra0", 64'(RA0_Q), 64'd0);
      check("arst_outs", 64'({DMA_DI, BUS_ADDR, BUS_REQ, BUS_WE, DMA_END}), 64'd0);
      DMA_LAST = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      abort_mode = 0;

      // WA0W on the same edge that consumes DMA_ACK of a write
      load_reg(1, 32'h20);
      DMA_ADD = 3'd2;
      push_bus(1, 27'h80, 32'h9999);
      issue_req(1, 32'h9999, 1);
      wait_ack_rise();
      #1;
      if (!CE_R) begin @(negedge CLK); #1; end
      DSO = 32'h300; WA0W = 1'b1;
      @(negedge CLK);
      WA0W = 1'b0;
      wait_ack_fall();
      wait_end_done(5);
      check("wa0_load_wins", 64'(WA0_Q), 64'hC00);

      // RA0 wrap
      load_reg(0, 32'h01FF_FFFF);
      check("ra0_top", 64'(RA0_Q), 64'h7FF_FFFC);
      push_bus(0, 27'h7FF_FFFC, 32'h0);
      exp_di_q.push_back(32'hDD);
      rd_q.push_back(32'hDD);
      xfer(0, 32'h0, 1);
      wait_end_done(6);
      check("ra0_wrap", 64'(RA0_Q), 64'h0);

      // synchronous soft reset
      load_reg(0, 32'h5);
      check("ra0_pre_res", 64'(RA0_Q), 64'h14);
      @(negedge CLK); RES_N = 1'b0;
      @(negedge CLK); RES_N = 1'b1;
      check("res_ra0", 64'(RA0_Q), 64'h0);
      check("res_wa0", 64'(WA0_Q), 64'h0);

      check("bus_q_drained", 64'(exp_q.size()), 64'd0);
      check("di_q_drained", 64'(exp_di_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_vec++;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/scu_dsp_dma.md
Name: scu_dsp_dma

Overview:
- Bus-side DMA engine for the SCU DSP.
- Holds the DSP read/write address registers RA0/WA0, which are loaded from the DSP D1 bus.
- Services the DSP's per-word DMA_REQ by running one external bus cycle per word and returning DMA_ACK and read data to the DSP.
- Signals transfer completion with DMA_END.
- Sits directly downstream of the DSP's DMA port, between the DSP and the SCU A/B-bus arbiter.

Parameters:
- ADDR_W, 27, external byte-address width.
- RA_INC, 4, byte increment applied to RA0 per read word.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- RES_N  in  1  synchronous soft reset, active low
- CE_R  in  1  rising-phase clock enable
- CE_F  in  1  falling-phase clock enable; CE_R and CE_F alternate, never coincide
- DSO  in  32  DSP D1 bus value
- RA0W  in  1  load RA0 from DSO (1-CLK pulse)
- WA0W  in  1  load WA0 from DSO (1-CLK pulse)
- DMA_ADD  in  3  write-address increment select
- DMA_DO  in  32  DSP->bus data
- DMA_WE  in  1  direction: 1 = DSP->bus (write), 0 = bus->DSP (read)
- DMA_REQ  in  1  DSP word request
- DMA_RUN  in  1  DSP transfer active (T0)
- DMA_LAST  in  1  current word is the last one
- DMA_DI  out  32  bus->DSP data
- DMA_ACK  out  1  word complete; consumed on a CE_R cycle
- DMA_END  out  1  transfer-complete pulse
- BUS_ADDR  out  ADDR_W  external address
- BUS_DO  out  32  write data
- BUS_DI  in  32  read data
- BUS_WE  out  1  bus write strobe qualifier
- BUS_REQ  out  1  bus cycle request
- BUS_ACK  in  1  1-CLK bus completion; BUS_DI valid in that cycle
- RA0_Q  out  ADDR_W  debug readback of RA0
- WA0_Q  out  ADDR_W  debug readback of WA0

Behaviour:
- Reset:
  - Asynchronous RST_N low clears all registers. All outputs are 0; RA0 = WA0 = 0; state = IDLE.
  - RES_N low (synchronous) has the same effect. It takes priority over everything except RST_N.
- Address load:
  - On RA0W or WA0W, the target register = {DSO[ADDR_W-3:0], 2'b00}. Loading is independent of CE.
  - A load in the same cycle as an increment of the same register wins.
- Write increment per word: DMA_ADD selects 0, 2, 4, 8, 16, 32, 64, 128 bytes (codes 0..7). DMA_ADD is sampled when leaving IDLE.
- Read increment per word: RA_INC.
- Address arithmetic wraps modulo 2^ADDR_W.
- FSM states: IDLE, BREQ, ACK, ENDW.
  - IDLE: when DMA_RUN && DMA_REQ && !DMA_ACK, latch the direction, and latch BUS_DO = DMA_DO if writing. BUS_ADDR = WA0 for a write, RA0 for a read. Go to BREQ.
  - BREQ: BUS_REQ = 1 and BUS_WE = direction, held stable until BUS_ACK.
    - On BUS_ACK: BUS_REQ = 0 in the next cycle, DMA_DI <= BUS_DI on a read, DMA_ACK <= 1, go to ACK.
  - ACK: DMA_ACK held high until the first CE_R cycle, where the DSP consumes it.
    - At that edge: DMA_ACK <= 0, and the used address register is incremented.
    - If DMA_LAST = 1 at that edge, DMA_END <= 1 and go to ENDW. Otherwise go to IDLE.
  - ENDW: DMA_END stays high until at least one CE_F edge has passed, then clears on the next CE_R edge; go to IDLE. The DSP therefore sees high-then-low on CE_F.
- Latency: DMA_REQ to BUS_REQ is 1 CLK. BUS_ACK to DMA_ACK is 1 CLK. DMA_ACK lasts until the next CE_R.
- DMA_DI is held stable from the BUS_ACK capture until the next word's capture.
- Abort: if DMA_RUN falls while in BREQ, the bus cycle still completes (BUS_REQ is held until BUS_ACK). The FSM then returns to IDLE with no DMA_ACK and no address increment. DMA_RUN falling in ACK or ENDW also forces IDLE at the next edge.
- DMA_REQ is ignored outside IDLE. Only one bus cycle is ever outstanding.

Test Plan:
- RA0W with DSO = 0x0010_0400 -> RA0_Q = 0x0040_1000 (27-bit). A 3-word read with BUS_DI = 0xA1, 0xA2, 0xA3 -> BUS_ADDR = 0x401000, 0x401004, 0x401008, DMA_WE = 0; DMA_DI carries each value during its DMA_ACK; final RA0_Q = 0x40100C; exactly one DMA_END high/low pair.
- WA0 = 0x100, DMA_ADD = 3, 2-word write with DMA_DO = 0x1234, 0x5678 -> BUS_WE = 1, BUS_ADDR = 0x100 then 0x108, BUS_DO matches each word; WA0_Q = 0x110.
- DMA_ADD = 0 write of 4 words -> all four BUS_ADDR = WA0; WA0 unchanged.
- BUS_ACK delayed 20 CLKs -> BUS_REQ and BUS_ADDR stable for the whole wait; DMA_ACK stays low until the cycle after BUS_ACK.
- DMA_RUN dropped during BREQ -> BUS_REQ held until BUS_ACK; no DMA_ACK, no DMA_END; address unchanged. Separately, RST_N pulsed mid-ACK -> all outputs 0 immediately.
- WA0W coinciding with the ACK-consume CE_R edge of a write -> WA0_Q equals the loaded value, not the incremented one. RA0 = 0x7FFFFFC, 1-word read -> RA0 wraps to 0.
